// File: rtl/lcd_pkg.sv
// Shared constants and types for the LCD layer scheduler: colours, layer tags,
// coordinate/address widths and the config FSM encoding.
package lcd_pkg;

   localparam int COORD_W = 11;
   localparam int ROM_AW  = 14;

   localparam logic [15:0] LCD_BACK_COLOR   = 16'hE7FF;
   localparam logic [15:0] LCD_CHAR_COLOR   = 16'hF800;
   localparam logic [15:0] LCD_BORDER_COLOR = 16'h001F;

   // SEL_BRD uses the spare code of the 2-bit layer select
   typedef enum logic [1:0] {
      SEL_NONE = 2'd0,
      SEL_PIC  = 2'd1,
      SEL_CHR  = 2'd2,
      SEL_BRD  = 2'd3
   } sel_e;

   typedef struct packed {
      sel_e       sel;
      logic [3:0] bit_idx;
   } tag_t;

   localparam tag_t TAG_NONE = '{sel: SEL_NONE, bit_idx: 4'd0};

   typedef enum logic {
      CFG_IDLE = 1'b0,
      CFG_PEND = 1'b1
   } cfg_state_e;

endpackage

// File: rtl/lcd_win_decode.sv
// Window hit test for one layer: half-open [org, org+size) in both axes,
// evaluated at COORD_W+1 bits so origin+size never wraps.
module lcd_win_decode
   import lcd_pkg::*;
#(
   parameter int WIN_W = 100,
   parameter int WIN_H = 100
) (
   input  logic [COORD_W-1:0] org_x_i,
   input  logic [COORD_W-1:0] org_y_i,
   input  logic [COORD_W-1:0] x_i,
   input  logic [COORD_W-1:0] y_i,
   output logic               hit_o,
   output logic               below_o,
   output logic [COORD_W-1:0] rel_x_o,
   output logic [COORD_W-1:0] rel_y_o
);

   typedef logic [COORD_W:0] coord_ext_t;

   coord_ext_t x_s;
   coord_ext_t y_s;
   coord_ext_t ox_s;
   coord_ext_t oy_s;
   coord_ext_t x_end_s;
   coord_ext_t y_end_s;

   assign x_s     = {1'b0, x_i};
   assign y_s     = {1'b0, y_i};
   assign ox_s    = {1'b0, org_x_i};
   assign oy_s    = {1'b0, org_y_i};
   assign x_end_s = ox_s + coord_ext_t'(WIN_W);
   assign y_end_s = oy_s + coord_ext_t'(WIN_H);

   assign hit_o   = (x_s >= ox_s) && (x_s < x_end_s) && (y_s >= oy_s) && (y_s < y_end_s);
   assign below_o = (y_s >= y_end_s);
   assign rel_x_o = x_i - org_x_i;
   assign rel_y_o = y_i - org_y_i;

endmodule

// File: rtl/lcd_layer_sched.sv
// Picture/character layer scheduler on a shared single-port pixel ROM.
// Optional 1-px window border: define LCD_LAYER_BORDER_EN.
module lcd_layer_sched
   import lcd_pkg::*;
#(
   parameter int          PIC_W      = 100,
   parameter int          PIC_H      = 100,
   parameter int          CHR_W      = 128,
   parameter int          CHR_H      = 32,
   parameter int          CHR_BASE   = 10000,
   parameter int          ROM_LAT    = 1,
   parameter logic [15:0] BACK_COLOR = LCD_BACK_COLOR,
   parameter logic [15:0] CHAR_COLOR = LCD_CHAR_COLOR,
   parameter int          PIC_X0     = 1,
   parameter int          PIC_Y0     = 1,
   parameter int          CHR_X0     = 1,
   parameter int          CHR_Y0     = 110
) (
   input  logic               lcd_pclk,
   input  logic               rst_n,
   input  logic               frame_start,
   input  logic [COORD_W-1:0] pixel_xpos,
   input  logic [COORD_W-1:0] pixel_ypos,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   input  logic               cfg_sel,
   input  logic [COORD_W-1:0] cfg_x,
   input  logic [COORD_W-1:0] cfg_y,
   output logic               cfg_pending,
   output logic [ROM_AW-1:0]  rom_addr,
   output logic               rom_rden,
   input  logic [15:0]        rom_q,
   output logic [15:0]        pixel_data
);

   localparam int CHR_WORDS = CHR_W / 16;

   cfg_state_e         state_q, state_d;
   logic               latch_s, commit_s;
   logic               cfg_ready_q, cfg_pending_q;
   logic [COORD_W-1:0] pic_x_q, pic_y_q, chr_x_q, chr_y_q;
   logic [COORD_W-1:0] shd_pic_x_q, shd_pic_y_q, shd_chr_x_q, shd_chr_y_q;

   logic               pic_hit_s, pic_below_s, chr_hit_s, chr_below_s;
   logic [COORD_W-1:0] pic_rel_x_s, pic_rel_y_s, chr_rel_x_s, chr_rel_y_s;
   logic [ROM_AW-1:0]  chr_row_s, chr_addr_s;
   logic [ROM_AW-1:0]  pic_cnt_q, pic_cnt_d;
   logic [ROM_AW-1:0]  rom_addr_q, rom_addr_d;
   logic               rom_rden_q, rom_rden_d;
   sel_e               pic_sel_s, chr_sel_s;
   tag_t               tag_s, tag_out_s;
   tag_t               tag_pipe_q [0:ROM_LAT];
   logic [15:0]        pixel_q, pixel_d;
   logic               unused_s;

   // Config FSM next state: accept into a shadow in IDLE, commit on frame_start in PEND
   always_comb begin
      state_d  = state_q;
      latch_s  = 1'b0;
      commit_s = 1'b0;
      case (state_q)
         CFG_IDLE: begin
            if (cfg_valid) begin
               latch_s = 1'b1;
               state_d = CFG_PEND;
            end else begin
               state_d = CFG_IDLE;
            end
         end
         CFG_PEND: begin
            if (frame_start) begin
               commit_s = 1'b1;
               state_d  = CFG_IDLE;
            end else begin
               state_d = CFG_PEND;
            end
         end
         default: state_d = CFG_IDLE;
      endcase
   end

   // Config FSM state and its registered handshake outputs
   always_ff @(posedge lcd_pclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= CFG_IDLE;
         cfg_ready_q   <= 1'b1;
         cfg_pending_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cfg_ready_q   <= (state_d == CFG_IDLE);
         cfg_pending_q <= (state_d == CFG_PEND);
      end
   end

   // Shadow and active origins; active ones only move at frame_start
   always_ff @(posedge lcd_pclk or negedge rst_n) begin
      if (!rst_n) begin
         shd_pic_x_q <= COORD_W'(PIC_X0);
         shd_pic_y_q <= COORD_W'(PIC_Y0);
         shd_chr_x_q <= COORD_W'(CHR_X0);
         shd_chr_y_q <= COORD_W'(CHR_Y0);
         pic_x_q     <= COORD_W'(PIC_X0);
         pic_y_q     <= COORD_W'(PIC_Y0);
         chr_x_q     <= COORD_W'(CHR_X0);
         chr_y_q     <= COORD_W'(CHR_Y0);
      end else begin
         if (latch_s && !cfg_sel) begin
            shd_pic_x_q <= cfg_x;
            shd_pic_y_q <= cfg_y;
         end
         if (latch_s && cfg_sel) begin
            shd_chr_x_q <= cfg_x;
            shd_chr_y_q <= cfg_y;
         end
         if (commit_s) begin
            pic_x_q <= shd_pic_x_q;
            pic_y_q <= shd_pic_y_q;
            chr_x_q <= shd_chr_x_q;
            chr_y_q <= shd_chr_y_q;
         end
      end
   end

   lcd_win_decode #(.WIN_W(PIC_W), .WIN_H(PIC_H)) u_pic_dec (
      .org_x_i (pic_x_q),
      .org_y_i (pic_y_q),
      .x_i     (pixel_xpos),
      .y_i     (pixel_ypos),
      .hit_o   (pic_hit_s),
      .below_o (pic_below_s),
      .rel_x_o (pic_rel_x_s),
      .rel_y_o (pic_rel_y_s)
   );

   lcd_win_decode #(.WIN_W(CHR_W), .WIN_H(CHR_H)) u_chr_dec (
      .org_x_i (chr_x_q),
      .org_y_i (chr_y_q),
      .x_i     (pixel_xpos),
      .y_i     (pixel_ypos),
      .hit_o   (chr_hit_s),
      .below_o (chr_below_s),
      .rel_x_o (chr_rel_x_s),
      .rel_y_o (chr_rel_y_s)
   );

   // Constant multiplier: reduces to shift/add, CHR_WORDS is a power of two by default
   assign chr_row_s  = ROM_AW'(chr_rel_y_s) * ROM_AW'(CHR_WORDS);
   assign chr_addr_s = ROM_AW'(CHR_BASE) + chr_row_s + ROM_AW'(chr_rel_x_s[COORD_W-1:4]);

`ifdef LCD_LAYER_BORDER_EN
   assign pic_sel_s = ((pic_rel_x_s == '0) || (pic_rel_x_s == COORD_W'(PIC_W - 1)) ||
                       (pic_rel_y_s == '0) || (pic_rel_y_s == COORD_W'(PIC_H - 1))) ? SEL_BRD : SEL_PIC;
   assign chr_sel_s = ((chr_rel_x_s == '0) || (chr_rel_x_s == COORD_W'(CHR_W - 1)) ||
                       (chr_rel_y_s == '0) || (chr_rel_y_s == COORD_W'(CHR_H - 1))) ? SEL_BRD : SEL_CHR;
   assign unused_s  = chr_below_s;
`else
   assign pic_sel_s = SEL_PIC;
   assign chr_sel_s = SEL_CHR;
   assign unused_s  = ^{chr_below_s, pic_rel_x_s, pic_rel_y_s};
`endif

   // Stage 0 arbitration: picture wins the ROM port where windows overlap
   always_comb begin
      rom_addr_d    = rom_addr_q;
      rom_rden_d    = 1'b0;
      tag_s         = TAG_NONE;
      if (pic_hit_s) begin
         rom_addr_d = pic_cnt_q;
         rom_rden_d = 1'b1;
         tag_s.sel  = pic_sel_s;
      end else if (chr_hit_s) begin
         rom_addr_d    = chr_addr_s;
         rom_rden_d    = 1'b1;
         tag_s.sel     = chr_sel_s;
         tag_s.bit_idx = ~chr_rel_x_s[3:0];
      end else begin
         rom_addr_d = rom_addr_q;
      end
   end

   // Picture word counter: raster order within the window, restarts each frame
   always_comb begin
      pic_cnt_d = pic_cnt_q;
      if (frame_start) begin
         pic_cnt_d = '0;
      end else if (pic_below_s) begin
         pic_cnt_d = '0;
      end else if (pic_hit_s) begin
         pic_cnt_d = pic_cnt_q + ROM_AW'(1);
      end else begin
         pic_cnt_d = pic_cnt_q;
      end
   end

   // Stage 1 registers: ROM request and picture counter
   always_ff @(posedge lcd_pclk or negedge rst_n) begin
      if (!rst_n) begin
         rom_addr_q <= '0;
         rom_rden_q <= 1'b0;
         pic_cnt_q  <= '0;
      end else begin
         rom_addr_q <= rom_addr_d;
         rom_rden_q <= rom_rden_d;
         pic_cnt_q  <= pic_cnt_d;
      end
   end

   // Tag delay line keeps the layer decision aligned with rom_q
   always_ff @(posedge lcd_pclk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i <= ROM_LAT; i++) begin
            tag_pipe_q[i] <= TAG_NONE;
         end
      end else begin
         tag_pipe_q[0] <= tag_s;
         for (int i = 1; i <= ROM_LAT; i++) begin
            tag_pipe_q[i] <= tag_pipe_q[i-1];
         end
      end
   end

   assign tag_out_s = tag_pipe_q[ROM_LAT];

   // Final colour select from the aligned tag and ROM word
   always_comb begin
      pixel_d = BACK_COLOR;
      case (tag_out_s.sel)
         SEL_PIC: pixel_d = rom_q;
         SEL_CHR: pixel_d = rom_q[tag_out_s.bit_idx] ? CHAR_COLOR : BACK_COLOR;
         SEL_BRD: pixel_d = LCD_BORDER_COLOR;
         default: pixel_d = BACK_COLOR;
      endcase
   end

   // Registered pixel output
   always_ff @(posedge lcd_pclk or negedge rst_n) begin
      if (!rst_n) begin
         pixel_q <= BACK_COLOR;
      end else begin
         pixel_q <= pixel_d;
      end
   end

   assign cfg_ready   = cfg_ready_q;
   assign cfg_pending = cfg_pending_q;
   assign rom_addr    = rom_addr_q;
   assign rom_rden    = rom_rden_q;
   assign pixel_data  = pixel_q;

endmodule

// File: tb/tb_lcd_layer_sched.sv
// Bench for lcd_layer_sched: raster and random coordinate streams compared every
// cycle against a window/raster reference model, plus pinned literal points.
module tb_lcd_layer_sched;

   localparam int          PIC_W    = 100;
   localparam int          PIC_H    = 100;
   localparam int          CHR_W    = 128;
   localparam int          CHR_H    = 32;
   localparam int          CHR_BASE = 10000;
   localparam logic [15:0] BACK     = 16'hE7FF;
   localparam logic [15:0] CHARC    = 16'hF800;

   logic        lcd_pclk = 1'b0;
   logic        rst_n;
   logic        frame_start;
   logic [10:0] pixel_xpos, pixel_ypos;
   logic        cfg_valid, cfg_ready, cfg_sel, cfg_pending;
   logic [10:0] cfg_x, cfg_y;
   logic [13:0] rom_addr;
   logic        rom_rden;
   logic [15:0] rom_q;
   logic [15:0] pixel_data;

   lcd_layer_sched dut (
      .lcd_pclk    (lcd_pclk),
      .rst_n       (rst_n),
      .frame_start (frame_start),
      .pixel_xpos  (pixel_xpos),
      .pixel_ypos  (pixel_ypos),
      .cfg_valid   (cfg_valid),
      .cfg_ready   (cfg_ready),
      .cfg_sel     (cfg_sel),
      .cfg_x       (cfg_x),
      .cfg_y       (cfg_y),
      .cfg_pending (cfg_pending),
      .rom_addr    (rom_addr),
      .rom_rden    (rom_rden),
      .rom_q       (rom_q),
      .pixel_data  (pixel_data)
   );

   always #5 lcd_pclk = ~lcd_pclk;

   logic [15:0] mem [0:16383];
   always @(posedge lcd_pclk) if (rom_rden) rom_q <= mem[rom_addr];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int ox [2], oy [2], sx [2], sy [2];
   bit pend;
   int pic_seen;
   bit lit_on;

   typedef struct {
      int          due;
      logic [15:0] val;
      int          lit;
   } pix_t;
   pix_t pq [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      ox[0] = 1; oy[0] = 1; ox[1] = 1; oy[1] = 110;
      sx = ox; sy = oy;
      pend = 1'b0;
      pic_seen = 0;
      pq.delete();
   endtask

   function automatic bit inwin(int x, int y, int wx, int wy, int w, int h);
      return (x >= wx) && (x < wx + w) && (y >= wy) && (y < wy + h);
   endfunction

   task automatic step(input int x, input int y, input bit fs, input bit cv, input bit cs,
                       input int nx, input int ny, input int lr);
      bit          ip, ic;
      int          exp_a, lit_a, lit_p, rx;
      logic [15:0] w, pix;
      pix_t        e;
      pixel_xpos  = 11'(x);
      pixel_ypos  = 11'(y);
      frame_start = fs;
      cfg_valid   = cv;
      cfg_sel     = cs;
      cfg_x       = 11'(nx);
      cfg_y       = 11'(ny);
      ip = inwin(x, y, ox[0], oy[0], PIC_W, PIC_H);
      ic = inwin(x, y, ox[1], oy[1], CHR_W, CHR_H);
      exp_a = 0;
      pix   = BACK;
      if (ip) begin
         exp_a = pic_seen % 16384;
         pix   = mem[exp_a];
      end else if (ic) begin
         rx    = x - ox[1];
         exp_a = CHR_BASE + (y - oy[1]) * (CHR_W / 16) + rx / 16;
         w     = mem[exp_a];
         pix   = w[15 - (rx % 16)] ? CHARC : BACK;
      end
      lit_a = -1;
      lit_p = -1;
      if (lit_on) begin
         if (x == 1 && y == 1)     lit_a = 0;
         if (x == 100 && y == 1)   lit_a = 99;
         if (x == 100 && y == 100) begin lit_a = 9999; lit_p = 9999; end
         if (x == 0 && y == 0)     lit_p = 16'hE7FF;
         if (x == 33 && y == 115)  lit_p = 16'hF800;
         if (x == 34 && y == 115)  lit_p = 16'hE7FF;
      end
      if (fs)                     pic_seen = 0;
      else if (y >= oy[0] + PIC_H) pic_seen = 0;
      else if (ip)                pic_seen++;
      if (pend) begin
         if (fs) begin
            ox = sx; oy = sy; pend = 1'b0;
         end
      end else if (cv) begin
         sx[cs] = nx; sy[cs] = ny; pend = 1'b1;
      end
      @(posedge lcd_pclk);
      #1;
      cyc++;
      chk("rden", rom_rden, ip || ic);
      if (ip || ic) chk("addr", rom_addr, exp_a);
      if (lit_a >= 0) chk("addr_lit", rom_addr, lit_a);
      if (lr >= 0) chk("rden_lit", rom_rden, lr);
      chk("cfg_ready", cfg_ready, !pend);
      chk("cfg_pending", cfg_pending, pend);
      if (pq.size() > 0 && pq[0].due == cyc) begin
         e = pq.pop_front();
         chk("pixel", pixel_data, e.val);
         if (e.lit >= 0) chk("pixel_lit", pixel_data, e.lit);
      end
      pq.push_back('{due: cyc + 2, val: pix, lit: lit_p});
   endtask

   task automatic px(input int x, input int y);
      step(x, y, 1'b0, 1'b0, 1'b0, 0, 0, -1);
   endtask

   task automatic fstart(input bit cv, input bit cs, input int nx, input int ny);
      step(0, 0, 1'b1, cv, cs, nx, ny, -1);
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, "_pixel"}, pixel_data, 16'hE7FF);
      chk({tag, "_ready"}, cfg_ready, 1'b1);
      chk({tag, "_pending"}, cfg_pending, 1'b0);
      chk({tag, "_rden"}, rom_rden, 1'b0);
      chk({tag, "_addr"}, rom_addr, 14'd0);
   endtask

   task automatic rand_steps(input int n);
      int x, y, r;
      bit cs;
      for (int i = 0; i < n; i++) begin
         r  = $urandom_range(0, 2);
         x  = (r == 0) ? $urandom_range(0, 15) : (r == 1) ? $urandom_range(1170, 1279)
                                                           : $urandom_range(40, 190);
         y  = ($urandom_range(0, 1) == 0) ? $urandom_range(40, 140) : $urandom_range(595, 705);
         cs = 1'($urandom_range(0, 1));
         step(x, y, $urandom_range(0, 499) == 0, $urandom_range(0, 199) == 0, cs,
              cs ? $urandom_range(0, 150) : $urandom_range(0, 1200), $urandom_range(0, 650), -1);
      end
   endtask

   initial begin
      for (int a = 0; a < 16384; a++) mem[a] = (a < 10000) ? 16'(a) : 16'($urandom);
      mem[CHR_BASE + 8 * 5 + 2] = 16'h8000;
      rst_n = 1'b0; frame_start = 1'b0; cfg_valid = 1'b0; cfg_sel = 1'b0;
      cfg_x = 11'd0; cfg_y = 11'd0; pixel_xpos = 11'd0; pixel_ypos = 11'd0;
      lit_on = 1'b0;
      model_reset();
      #12;
      reset_checks("reset");
      @(posedge lcd_pclk); #1;
      @(posedge lcd_pclk); #1;
      rst_n = 1'b1;

      // default origins; picture move requested mid-frame, second request refused
      lit_on = 1'b1;
      fstart(1'b0, 1'b0, 0, 0);
      for (int y = 0; y <= 142; y++) begin
         for (int x = 0; x <= 130; x++) begin
            if (x == 0 && y == 60)      step(x, y, 1'b0, 1'b1, 1'b0, 200, 10, -1);
            else if (x == 0 && y == 61) step(x, y, 1'b0, 1'b1, 1'b1, $urandom_range(0, 300),
                                             $urandom_range(0, 200), -1);
            else                        px(x, y);
         end
      end
      lit_on = 1'b0;

      // picture at (200,10)
      fstart(1'b0, 1'b0, 0, 0);
      for (int y = 5; y <= 115; y++) for (int x = 190; x <= 310; x++) px(x, y);

      // handshake together with frame_start in IDLE: latched, not committed
      fstart(1'b1, 1'b1, 50, 50);
      for (int y = 105; y <= 120; y++) for (int x = 0; x <= 140; x++) px(x, y);

      fstart(1'b0, 1'b0, 0, 0);
      step(0, 0, 1'b0, 1'b1, 1'b0, 1, 1, -1);
      px(0, 0);

      // overlapping windows, picture has priority
      fstart(1'b0, 1'b0, 0, 0);
      for (int y = 40; y <= 90; y++) for (int x = 40; x <= 190; x++) px(x, y);
      step(0, 0, 1'b0, 1'b1, 1'b0, 1180, 600, -1);

      // right-edge window: no wrap at 12 bits
      fstart(1'b0, 1'b0, 0, 0);
      step(1179, 600, 1'b0, 1'b0, 1'b0, 0, 0, 0);
      step(1180, 600, 1'b0, 1'b0, 1'b0, 0, 0, 1);
      step(1279, 600, 1'b0, 1'b0, 1'b0, 0, 0, 1);
      step(0,    600, 1'b0, 1'b0, 1'b0, 0, 0, 0);
      step(1280, 600, 1'b0, 1'b0, 1'b0, 0, 0, 0);

      rand_steps(1500);

      // asynchronous reset in the middle of a frame
      #2;
      rst_n = 1'b0;
      #1;
      reset_checks("midreset");
      model_reset();
      @(posedge lcd_pclk); #1;
      @(posedge lcd_pclk); #1;
      rst_n = 1'b1;
      px(0, 0);
      rand_steps(1500);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
